// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a framed byte stream (LEN, payload, XOR checksum), writes
// little-endian 32-bit words to sequential byte addresses and holds the CPU until the load is good.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [63:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [63:0] MaxWords = 64'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  acc_q, acc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] buf_q, buf_d;
  logic        im_we_q, im_we_d;
  logic [63:0] im_addr_q, im_addr_d;
  logic [31:0] im_wdata_q, im_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] words_q, words_d;
  logic [15:0] new_len;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    words_d    = words_q;
    new_len    = {in_data, len_q[7:0]};
    in_ready   = (state_q == StLenLo) || (state_q == StLenHi) ||
                 (state_q == StData)  || (state_q == StCheck);
    accept     = in_valid & in_ready;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLenLo;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = 16'd0;
          acc_d      = 8'd0;
          byte_cnt_d = 2'd0;
          len_d      = 16'd0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = in_data;
          acc_d      = acc_q ^ in_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = in_data;
          acc_d       = acc_q ^ in_data;
          byte_cnt_d  = 2'd0;
          if ({48'd0, new_len} > MaxWords) begin
            state_d = StError;
            error_d = 1'b1;
          end else if (new_len == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          acc_d      = acc_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd0) begin
            buf_d[7:0] = in_data;
          end else if (byte_cnt_q == 2'd1) begin
            buf_d[15:8] = in_data;
          end else if (byte_cnt_q == 2'd2) begin
            buf_d[23:16] = in_data;
          end else begin
            // Fourth byte: the registered write strobe and count land together next cycle.
            im_we_d    = 1'b1;
            im_wdata_d = {in_data, buf_q};
            im_addr_d  = BASE_ADDR + {46'd0, words_q, 2'b00};
            words_d    = words_q + 16'd1;
            if (words_q + 16'd1 == len_q) begin
              state_d = StCheck;
            end
          end
        end
      end
      StCheck: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = StError;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= 16'd0;
      acc_q      <= 8'd0;
      byte_cnt_q <= 2'd0;
      buf_q      <= 24'd0;
      im_we_q    <= 1'b0;
      im_addr_q  <= 64'd0;
      im_wdata_q <= 32'd0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and randomized frames checked against a frame-level model.
module tb_instr_mem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        im_we;
  logic [63:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  instr_mem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(64'h0)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed traffic
  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          accepts;

  always @(negedge clock) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
    end
    if (in_valid && in_ready) accepts++;
  end

  // Model expectations
  logic [7:0]  frame[$];
  logic [63:0] e_addr[$];
  logic [31:0] e_data[$];
  logic        e_done, e_err;
  int          e_words, e_cons;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Frame-level reference: parse LEN, slice words, XOR all bytes before CHK.
  task automatic model();
    int len;
    logic [7:0] x;
    e_addr.delete();
    e_data.delete();
    len = int'(frame[0]) + 256 * int'(frame[1]);
    if (len > 256) begin
      e_err = 1'b1; e_done = 1'b0; e_words = 0; e_cons = 2;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * len; i++) x ^= frame[i];
    for (int w = 0; w < len; w++) begin
      e_addr.push_back(64'(4 * w));
      e_data.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
    end
    e_words = len;
    e_cons  = 3 + 4 * len;
    e_done  = (frame[2 + 4 * len] == x);
    e_err   = !e_done;
  endtask

  task automatic make_random_frame(input int len, input bit bad);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(len));
    frame.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * len; i++) frame.push_back(8'($urandom_range(0, 255)));
    x = 8'd0;
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Idle 'gap' cycles with data already on the bus, then present it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_data  = b;
    in_valid = 1'b0;
    repeat (gap) cyc();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!in_ready) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic run_frame(input string tag, input int max_gap, input int stall_idx,
                           input int start_idx);
    model();
    wr_addr.delete();
    wr_data.delete();
    accepts = 0;
    pulse_start();
    chk({tag, "_hold_on_start"}, {61'd0, cpu_hold, done, error}, 64'b100);
    for (int i = 0; i < e_cons; i++) begin
      if (i == start_idx) start = 1'b1;
      send_byte(frame[i], (i == stall_idx) ? 5 : $urandom_range(0, max_gap));
      start = 1'b0;
    end
    cyc();
    chk({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(e_addr.size()));
    for (int i = 0; i < e_addr.size() && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], e_addr[i]);
      chk({tag, "_data"}, {32'd0, wr_data[i]}, {32'd0, e_data[i]});
    end
    chk({tag, "_done"}, {63'd0, done}, {63'd0, e_done});
    chk({tag, "_error"}, {63'd0, error}, {63'd0, e_err});
    chk({tag, "_hold"}, {63'd0, cpu_hold}, {63'd0, ~e_done});
    chk({tag, "_words"}, {48'd0, words_loaded}, 64'(e_words));
    chk({tag, "_accepts"}, 64'(accepts), 64'(e_cons));
    chk({tag, "_ready_off"}, {63'd0, in_ready}, 64'd0);
  endtask

  task automatic load_t1();
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00, 8'h72};
  endtask

  initial begin
    #2;
    chk("reset_outs", {im_we, in_ready, cpu_hold, done, error, 59'd0}, 64'd0);
    chk("reset_words", {48'd0, words_loaded}, 64'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // 1: golden two-word frame
    load_t1();
    run_frame("t1", 0, -1, -1);
    chk("t1_w0", {wr_addr[0], 32'd0} ^ {32'd0, wr_data[0]}, {64'h0, 32'h0} ^ 64'h00A00513);

    // 2: bad checksum
    load_t1();
    frame[10] = 8'h73;
    run_frame("t2", 0, -1, -1);

    // 3: empty program
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("t3", 0, -1, -1);

    // 4: length overflow (257 words)
    frame = '{8'h01, 8'h01};
    run_frame("t4", 0, -1, -1);

    // 5: random gaps plus a 5-cycle stall
    load_t1();
    run_frame("t5", 3, 4, -1);

    // 6a: start pulse in the middle of payload is ignored
    load_t1();
    run_frame("t6a", 0, -1, 5);

    // 6b: reset after six payload bytes
    load_t1();
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(frame[i], 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("t6b_outs", {im_we, in_ready, cpu_hold, done, error, 59'd0}, 64'd0);
    chk("t6b_addr_data", im_addr ^ {32'd0, im_wdata}, 64'd0);
    chk("t6b_words", {48'd0, words_loaded}, 64'd0);
    repeat (3) cyc();
    chk("t6b_nwrites", 64'(wr_addr.size()), 64'd1);
    reset = 1'b1;
    cyc();
    load_t1();
    run_frame("t6c", 0, -1, -1);

    // Randomized frames, good and bad checksums
    for (int r = 0; r < 4; r++) begin
      make_random_frame($urandom_range(1, 6), ($urandom_range(0, 1) == 1));
      run_frame("rand", 2, -1, -1);
    end

    // Largest legal program: exactly 2**ADDR_WIDTH words
    make_random_frame(256, 1'b0);
    run_frame("max", 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
